// File: rtl/md5_result_check.sv
// md5_result_check: adds the MD5 IV to the last hash_op state, compares the digest
// with the host target and runs the found/done search session.
module md5_result_check #(
    parameter logic [31:0] IV_A = 32'h67452301,
    parameter logic [31:0] IV_B = 32'hefcdab89,
    parameter logic [31:0] IV_C = 32'h98badcfe,
    parameter logic [31:0] IV_D = 32'h10325476
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [31:0]  a_in,
    input  logic [31:0]  b_in,
    input  logic [31:0]  c_in,
    input  logic [31:0]  d_in,
    input  logic [151:0] m_in,
    input  logic         valid_in,
    input  logic [127:0] target_hash,
    input  logic [31:0]  expected_count,
    input  logic         start,
    input  logic         ack,
    output logic         match_found,
    output logic         search_done,
    output logic [151:0] match_string,
    output logic [31:0]  hash_count,
    output logic         busy,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        FOUND  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    sum_a_q, sum_a_d, sum_b_q, sum_b_d;
    logic [31:0]    sum_c_q, sum_c_d, sum_d_q, sum_d_d;
    logic [151:0]   m_q, m_d;
    logic           v_q, v_d;
    logic [31:0]    count_q, count_d, count_inc;
    logic [151:0]   str_q, str_d;
    logic [127:0]   digest;
    logic           eq;
    logic           evt;
    logic           flush;

    function automatic logic [31:0] swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    assign digest = {swap32(sum_a_q), swap32(sum_b_q), swap32(sum_c_q), swap32(sum_d_q)};
    assign eq     = (digest == target_hash);

    // Handshake: valid_in is taken into stage 1 only on edges with en=1, and a stage-1
    // result is consumed by the session on an edge with en=1 and its valid set; no backpressure.
    assign evt       = en & v_q;
    assign count_inc = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        str_d   = str_q;
        flush   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEARCH;
                    count_d = '0;
                    str_d   = '0;
                    flush   = 1'b1;
                end
            end
            SEARCH: begin
                if (evt) begin
                    count_d = count_inc;
                    // Saturated count never reaches 0, so expected_count=0 only ends on a match.
                    if (eq) begin
                        state_d = FOUND;
                        str_d   = m_q;
                    end else if (count_inc == expected_count) begin
                        state_d = DONE;
                    end
                end
            end
            FOUND, DONE: begin
                if (ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sum_a_d = sum_a_q;
        sum_b_d = sum_b_q;
        sum_c_d = sum_c_q;
        sum_d_d = sum_d_q;
        m_d     = m_q;
        v_d     = v_q;
        if (en) begin
            sum_a_d = a_in + IV_A;
            sum_b_d = b_in + IV_B;
            sum_c_d = c_in + IV_C;
            sum_d_d = d_in + IV_D;
            m_d     = m_in;
            v_d     = valid_in;
        end
        if (flush) v_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            str_q   <= '0;
            sum_a_q <= '0;
            sum_b_q <= '0;
            sum_c_q <= '0;
            sum_d_q <= '0;
            m_q     <= '0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            str_q   <= str_d;
            sum_a_q <= sum_a_d;
            sum_b_q <= sum_b_d;
            sum_c_q <= sum_c_d;
            sum_d_q <= sum_d_d;
            m_q     <= m_d;
            v_q     <= v_d;
        end
    end

    assign match_found  = (state_q == FOUND);
    assign search_done  = (state_q == FOUND) || (state_q == DONE);
    assign busy         = (state_q == SEARCH);
    assign hash_count   = count_q;
    assign match_string = str_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_md5_result_check.sv
// Directed bench for md5_result_check: session-level model compared every cycle,
// plus literal expectations at the key points of each scenario.
module tb_md5_result_check;

    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hefcdab89;
    localparam logic [31:0] IV_C = 32'h98badcfe;
    localparam logic [31:0] IV_D = 32'h10325476;
    localparam logic [127:0] TGT = 128'h0123456789abcdeffedcba9876543210;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b1;
    logic [31:0]  a_in = '0, b_in = '0, c_in = '0, d_in = '0;
    logic [151:0] m_in = '0;
    logic         valid_in = 1'b0;
    logic [127:0] target_hash = TGT;
    logic [31:0]  expected_count = '0;
    logic         start = 1'b0;
    logic         ack = 1'b0;
    logic         match_found, search_done, busy;
    logic [151:0] match_string;
    logic [31:0]  hash_count;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_pass = 0;

    md5_result_check dut (
        .clk(clk), .reset(reset), .en(en),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
        .m_in(m_in), .valid_in(valid_in),
        .target_hash(target_hash), .expected_count(expected_count),
        .start(start), .ack(ack),
        .match_found(match_found), .search_done(search_done),
        .match_string(match_string), .hash_count(hash_count),
        .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [151:0] act, input logic [151:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Digest byte 0 is the low byte of (A + IV_A): MD5 words are little-endian.
    function automatic logic [127:0] digest_of(input logic [31:0] a, input logic [31:0] b,
                                               input logic [31:0] c, input logic [31:0] d);
        logic [31:0]  w [4];
        logic [127:0] res;
        w[0] = a + IV_A;
        w[1] = b + IV_B;
        w[2] = c + IV_C;
        w[3] = d + IV_D;
        res = '0;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++)
                res[127 - 32*i - 8*k -: 8] = w[i][8*k +: 8];
        return res;
    endfunction

    // ---------------- behavioural model ----------------
    bit           md_busy = 0, md_found = 0, md_done = 0;
    bit           md_was_idle, md_evt;
    logic [31:0]  md_count = '0;
    logic [151:0] md_str = '0;
    bit           s1_v = 0;
    logic [127:0] s1_dig = '0;
    logic [151:0] s1_m = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            md_busy = 0; md_found = 0; md_done = 0;
            md_count = '0; md_str = '0;
            s1_v = 0; s1_dig = '0; s1_m = '0;
        end else begin
            md_was_idle = !(md_busy || md_found || md_done);
            md_evt = en && s1_v;
            if (md_was_idle) begin
                if (start) begin
                    md_busy = 1; md_count = '0; md_str = '0;
                end
            end else if (md_busy) begin
                if (md_evt) begin
                    if (md_count != 32'hFFFF_FFFF) md_count = md_count + 32'd1;
                    if (s1_dig == target_hash) begin
                        md_busy = 0; md_found = 1; md_str = s1_m;
                    end else if (md_count == expected_count) begin
                        md_busy = 0; md_done = 1;
                    end
                end
            end else if (ack) begin
                md_found = 0; md_done = 0;
            end
            if (en) begin
                s1_v = valid_in;
                s1_dig = digest_of(a_in, b_in, c_in, d_in);
                s1_m = m_in;
            end
            if (md_was_idle && start) s1_v = 0;
        end
    end

    always @(negedge clk) begin
        check("cmp_match_found", {151'd0, match_found}, {151'd0, md_found});
        check("cmp_search_done", {151'd0, search_done}, {151'd0, md_found | md_done});
        check("cmp_busy", {151'd0, busy}, {151'd0, md_busy});
        check("cmp_hash_count", {120'd0, hash_count}, {120'd0, md_count});
        check("cmp_match_string", match_string, md_str);
    end

    // ---------------- driver tasks ----------------
    task automatic idle_cycle();
        en = 1'b1; valid_in = 1'b0; start = 1'b0; ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] w, input logic [151:0] m);
        a_in = w; b_in = w; c_in = w; d_in = w; m_in = m;
        valid_in = 1'b1; en = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; en = 1'b1; valid_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1; en = 1'b1; valid_in = 1'b0;
        @(negedge clk);
        ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_match_found", {151'd0, match_found}, 152'd0);
        check("rst_search_done", {151'd0, search_done}, 152'd0);
        check("rst_busy", {151'd0, busy}, 152'd0);
        check("rst_hash_count", {120'd0, hash_count}, 152'd0);
        check("rst_state_idle", {150'd0, dbg_state}, 152'd0);

        // Match on the fifth result; zero state words plus IV give TGT exactly.
        expected_count = 32'd10;
        pulse_start();
        for (int i = 0; i < 4; i++) push(32'd1, 152'd100 + 152'(i));
        push(32'd0, 152'h1);
        idle_cycle();
        check("m5_match_found", {151'd0, match_found}, 152'd1);
        check("m5_hash_count", {120'd0, hash_count}, 152'd5);
        check("m5_match_string", match_string, 152'h1);
        check("m5_busy", {151'd0, busy}, 152'd0);
        check("m5_search_done", {151'd0, search_done}, 152'd1);

        // In FOUND: later match ignored, start ignored, ack returns to IDLE keeping results.
        push(32'd0, 152'h2);
        idle_cycle();
        check("found_keep_string", match_string, 152'h1);
        check("found_keep_count", {120'd0, hash_count}, 152'd5);
        pulse_start();
        check("found_start_ignored", {151'd0, match_found}, 152'd1);
        pulse_ack();
        check("ack_match_found", {151'd0, match_found}, 152'd0);
        check("ack_search_done", {151'd0, search_done}, 152'd0);
        check("ack_keep_count", {120'd0, hash_count}, 152'd5);
        check("ack_keep_string", match_string, 152'h1);

        // No match: three results, session ends in DONE.
        expected_count = 32'd3;
        pulse_start();
        check("nm_start_clears", {120'd0, hash_count}, 152'd0);
        for (int i = 0; i < 3; i++) push(32'd1, 152'd10 + 152'(i));
        idle_cycle();
        check("nm_search_done", {151'd0, search_done}, 152'd1);
        check("nm_match_found", {151'd0, match_found}, 152'd0);
        check("nm_hash_count", {120'd0, hash_count}, 152'd3);
        pulse_ack();

        // en stall with a matching result sitting in stage 1.
        expected_count = 32'd10;
        pulse_start();
        push(32'd1, 152'd20);
        push(32'd0, 152'd7);
        en = 1'b0;
        valid_in = 1'b1;
        a_in = 32'd1; b_in = 32'd1; c_in = 32'd1; d_in = 32'd1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_no_match", {151'd0, match_found}, 152'd0);
        end
        check("stall_count", {120'd0, hash_count}, 152'd1);
        idle_cycle();
        check("stall_release_match", {151'd0, match_found}, 152'd1);
        check("stall_release_count", {120'd0, hash_count}, 152'd2);
        check("stall_release_string", match_string, 152'd7);
        pulse_ack();

        // Misuse in SEARCH, then the last result also matches -> FOUND.
        expected_count = 32'd2;
        pulse_start();
        push(32'd1, 152'd8);
        pulse_start();
        check("search_start_ignored", {120'd0, hash_count}, 152'd1);
        pulse_ack();
        check("search_ack_ignored", {151'd0, busy}, 152'd1);
        push(32'd0, 152'd9);
        idle_cycle();
        check("last_match_found", {151'd0, match_found}, 152'd1);
        check("last_search_done", {151'd0, search_done}, 152'd1);
        check("last_hash_count", {120'd0, hash_count}, 152'd2);
        check("last_busy", {151'd0, busy}, 152'd0);
        pulse_ack();

        // Asynchronous reset mid-SEARCH with a match pending.
        expected_count = 32'd10;
        pulse_start();
        push(32'd1, 152'd30);
        push(32'd0, 152'd31);
        check("pre_reset_count", {120'd0, hash_count}, 152'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", {151'd0, busy}, 152'd0);
        check("arst_search_done", {151'd0, search_done}, 152'd0);
        check("arst_hash_count", {120'd0, hash_count}, 152'd0);
        check("arst_match_string", match_string, 152'd0);
        check("arst_state_idle", {150'd0, dbg_state}, 152'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) idle_cycle();
        check("post_reset_no_match", {151'd0, match_found}, 152'd0);
        check("post_reset_count", {120'd0, hash_count}, 152'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/md5_result_check.md
Name: md5_result_check

Overview:
- Sits at the tail of the 64-stage MD5 hash_op pipeline and consumes its a/b/c/d/m/valid stream.
- Adds the MD5 initial vector to the final state and forms the 128-bit digest in standard byte order.
- Compares the digest against a host-supplied target.
- Runs a search session: counts results, captures the first matching 19-character string, and reports found/done status to the host control logic.

Parameters:
- IV_A, 32'h67452301, MD5 initial A word added to a_in
- IV_B, 32'hefcdab89, MD5 initial B word
- IV_C, 32'h98badcfe, MD5 initial C word
- IV_D, 32'h10325476, MD5 initial D word

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  pipeline advance enable, the same signal driving the hash_op chain
- a_in, b_in, c_in, d_in  in  32 each  final state words from the last hash_op
- m_in  in  152  19-character message travelling with the result
- valid_in  in  1  result valid, qualified by en
- target_hash  in  128  digest to find; MSB byte is digest byte 0; must be stable while searching
- expected_count  in  32  number of results in the session
- start  in  1  single-cycle pulse that opens a session
- ack  in  1  single-cycle pulse that closes a finished session
- match_found  out  1  high in FOUND
- search_done  out  1  high in FOUND or DONE
- match_string  out  152  captured matching message
- hash_count  out  32  results counted this session
- busy  out  1  high in SEARCH

Behaviour:
- Reset (asynchronous, active-high) clears everything immediately, including mid-session:
  - all outputs 0
  - FSM goes to IDLE
  - pipeline registers 0, stage valids 0
- Digest: {swap32(a_in+IV_A), swap32(b_in+IV_B), swap32(c_in+IV_C), swap32(d_in+IV_D)}.
  - Additions are mod 2^32.
  - swap32 reverses the byte order within each word.
- Stage 1 (registered, advances only when en=1): registers the four sums, m_in and valid_in.
- Stage 2 (combinational from stage 1): computes the byte swap and eq = (digest == target_hash).
- Event: an event occurs when en=1 and stage-1 valid=1. The FSM acts on it at that same edge.
- Latency: valid_in sampled at edge N affects the FSM outputs at edge N+1 only if en=1 at N+1; with en held low the event waits.
- en=0: stage 1 and the FSM event logic hold. start and ack are still honoured.
- FSM states IDLE, SEARCH, FOUND, DONE:
  - IDLE: events are ignored.
    - start -> SEARCH.
    - On the start edge: hash_count=0, match_string=0, stage-1 valid cleared (flushes stale results).
  - SEARCH: each event increments hash_count, saturating at 32'hFFFFFFFF.
    - Event with eq=1 -> FOUND, and match_string captures the stage-1 m at that edge.
    - Event with eq=0 where the post-increment count == expected_count -> DONE.
    - Last result also matching -> FOUND wins.
    - expected_count=0 -> never enters DONE by count; the session ends only on a match.
  - FOUND: events are ignored. Later matches do not overwrite match_string or hash_count. ack -> IDLE.
  - DONE: events are ignored. ack -> IDLE.
- Pulses in the wrong state:
  - start outside IDLE is ignored.
  - ack outside FOUND/DONE is ignored.
- ack -> IDLE preserves hash_count and match_string until the next start.

Test Plan:
- Reset check: assert reset asynchronously mid-SEARCH with events pending -> all outputs 0 immediately, FSM in IDLE, no match reported after release.
- Match on fifth result:
  - target_hash=128'h0123456789abcdeffedcba9876543210, expected_count=10.
  - Send start, then a_in=b_in=c_in=d_in=0 with m_in=152'h1 on the fifth valid.
  - Required: match_found=1 one en-edge later, hash_count=5, match_string=152'h1, busy=0, search_done=1.
- No match:
  - expected_count=3, three non-matching results (a_in=1).
  - Required: DONE after the third event, search_done=1, match_found=0, hash_count=3.
- en stall: drop en for 4 cycles while a matching result sits in stage 1 -> match_found stays 0 until en returns, then rises on that edge; count increments exactly once.
- Last result matches: expected_count=2 and the second result matches -> FOUND (not DONE), hash_count=2.
- Protocol misuse and ack:
  - start pulsed during SEARCH -> hash_count not cleared.
  - ack in SEARCH -> no effect.
  - A second matching result while in FOUND -> match_string unchanged.
  - ack -> IDLE, with outputs retained until the next start.
